cmd_sched: RTL and testbench
============================

CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 SHALL have parameter BOT_PERIOD, default 8: game ticks between bot command issues in demo mode; legal range 1..255.
REQ-002 SHALL have parameter IDLE_TICKS, default 64: game ticks without player input before demo mode is entered; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick  input  1  one-cycle game-tick strobe.
REQ-006 SHALL have port usr_cmd  input  8  player command, sampled when usr_valid=1.
REQ-007 SHALL have port usr_valid  input  1  one-cycle player-command strobe.
REQ-008 SHALL have port bot_cmd  input  8  free-running random command from the bot LFSR, sampled only on bot issue.
REQ-009 SHALL have port force_manual  input  1  level; inhibits demo mode.
REQ-010 SHALL have port cmd_out  output  8  command to the game engine.
REQ-011 SHALL have port cmd_valid  output  1  cmd_out is valid.
REQ-012 SHALL have port cmd_ready  input  1  game engine accepts cmd_out.
REQ-013 SHALL have port demo_mode  output  1  bot is driving the game.
REQ-014 SHALL have port drop_cnt  output  8  count of overwritten player commands.

Function
REQ-015 SHALL register all outputs; no combinational path from any input to any output.
REQ-016 SHALL implement FSM states IDLE (cmd_valid=0) and ISSUE (cmd_valid=1).
REQ-017 SHALL, in IDLE, load cmd_out and enter ISSUE with this priority: (1) pending player command in the holding register; (2) usr_valid this cycle; (3) bot_due=1 and demo_mode=1, loading bot_cmd.
REQ-018 SHALL, when usr_valid arrives in IDLE with the holding register empty, assert cmd_valid with cmd_out=usr_cmd on the next cycle (1-cycle latency).
REQ-019 SHALL, in ISSUE, hold cmd_out and cmd_valid stable until cmd_ready=1, then return to IDLE on the following edge; cmd_ready while in IDLE SHALL be ignored.
REQ-020 SHALL store usr_cmd received while in ISSUE in a single-entry holding register.
REQ-021 SHALL, when usr_valid arrives with the holding register already full, overwrite the register with the newest command and increment drop_cnt, saturating at 255.
REQ-022 SHALL keep an idle counter that resets to 0 on usr_valid, increments on each tick otherwise, and saturates at IDLE_TICKS.
REQ-023 SHALL set demo_mode on the edge at which the idle counter reaches IDLE_TICKS while force_manual=0.
REQ-024 SHALL clear demo_mode, bot_due and the bot timer on the edge after usr_valid=1 or force_manual=1; force_manual=1 SHALL also hold the idle counter at 0.
REQ-025 SHALL, in demo mode, count ticks 0..BOT_PERIOD-1 with wrap, setting bot_due when a tick arrives at count BOT_PERIOD-1.
REQ-026 SHALL clear bot_due when the bot command is loaded; a second due event while bot_due=1 SHALL be discarded, never queued.
REQ-027 SHALL, when usr_valid and tick occur in the same cycle, apply usr_valid: idle counter goes to 0 and no tick is counted.
REQ-028 SHALL complete an in-flight ISSUE normally when demo_mode falls mid-handshake; the bot command is not withdrawn.

Reset
REQ-029 SHALL, while rst=0 (asynchronous): set FSM=IDLE, cmd_out=8'h00, cmd_valid=0, demo_mode=0, drop_cnt=0, holding register empty, idle counter, bot timer and bot_due all 0.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst returns high; a reset asserted during ISSUE drops that command.

Verification (bench parameters BOT_PERIOD=4, IDLE_TICKS=8)
REQ-031 SHALL cover: usr_valid with usr_cmd=8'h03, cmd_ready=1 -> cmd_valid=1 and cmd_out=8'h03 the next cycle, IDLE one cycle after that.
REQ-032 SHALL cover: cmd_ready=0, then three usr_valid strobes with 01, 02, 04 -> 01 is issued first, 04 is held, drop_cnt=1, and 04 issues after the first handshake.
REQ-033 SHALL cover: no input for 8 ticks -> demo_mode=1; every 4th tick after that issues the sampled bot_cmd with cmd_ready=1.
REQ-034 SHALL cover: in demo mode with cmd_ready=0, usr_valid arrives -> demo_mode=0 next cycle, the pending bot command is still held until ready, and the player command issues after it.
REQ-035 SHALL cover: force_manual=1 for 20 ticks -> demo_mode stays 0 and no bot issue occurs.
REQ-036 SHALL cover: rst=0 asynchronously during ISSUE -> cmd_valid=0, drop_cnt=0 and demo_mode=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/cmd_sched_if.sv
// cmd_sched_if: handshake/bus bundle between the command scheduler and its environment
// master: drives game tick, player/bot commands, force_manual and cmd_ready
// slave : the scheduler; drives cmd_out, cmd_valid, demo_mode and drop_cnt
interface cmd_sched_if;
  logic       tick;
  logic [7:0] usr_cmd;
  logic       usr_valid;
  logic [7:0] bot_cmd;
  logic       force_manual;
  logic [7:0] cmd_out;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       demo_mode;
  logic [7:0] drop_cnt;
  modport master (
    output tick, usr_cmd, usr_valid, bot_cmd, force_manual, cmd_ready,
    input  cmd_out, cmd_valid, demo_mode, drop_cnt
  );
  modport slave (
    input  tick, usr_cmd, usr_valid, bot_cmd, force_manual, cmd_ready,
    output cmd_out, cmd_valid, demo_mode, drop_cnt
  );
endinterface

// File: rtl/cmd_sched.sv
// cmd_sched: arbitrates player and demo-bot commands onto a valid/ready game-engine port
// clk : single clock, rising edge
// rst : asynchronous active-low reset
// bus : slave side of cmd_sched_if (tick, usr_cmd/usr_valid, bot_cmd, force_manual,
//       cmd_ready in; cmd_out/cmd_valid, demo_mode, drop_cnt out, all registered)
module cmd_sched #(
  parameter int unsigned BOT_PERIOD = 8,
  parameter int unsigned IDLE_TICKS = 64
) (
  input logic        clk,
  input logic        rst,
  cmd_sched_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_TICKS);
  localparam logic [7:0]  BT_LAST  = 8'(BOT_PERIOD - 1);
  state_t      state_q;
  logic [7:0]  cmd_out_q, hold_q, drop_cnt_q, bt_q, bt_d;
  logic        cmd_valid_q, hold_vld_q, demo_q, demo_d, bot_due_q, bot_due_d;
  logic [15:0] idle_q, idle_d;
  logic        clr, due_evt, bot_load;
  always_comb begin
    clr       = bus.usr_valid | bus.force_manual;
    due_evt   = demo_q && bus.tick && bt_q == BT_LAST;
    // bot only wins an idle slot when no player command is held or arriving
    bot_load  = state_q == IDLE && !hold_vld_q && !clr && bot_due_q && demo_q;
    idle_d    = clr ? '0 : (bus.tick && idle_q != IDLE_MAX) ? idle_q + 16'd1 : idle_q;
    demo_d    = !clr && (demo_q || idle_d == IDLE_MAX);
    bt_d      = clr ? '0 : (demo_q && bus.tick) ? (bt_q == BT_LAST ? '0 : bt_q + 8'd1) : bt_q;
    // a due event while already due collapses into the one pending issue
    bot_due_d = clr ? 1'b0 : due_evt ? 1'b1 : bot_load ? 1'b0 : bot_due_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_out_q   <= '0;
      cmd_valid_q <= 1'b0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      drop_cnt_q  <= '0;
      demo_q      <= 1'b0;
      bot_due_q   <= 1'b0;
      idle_q      <= '0;
      bt_q        <= '0;
    end else begin
      idle_q    <= idle_d;
      bt_q      <= bt_d;
      demo_q    <= demo_d;
      bot_due_q <= bot_due_d;
      case (state_q)
        IDLE: begin
          if (hold_vld_q) begin
            cmd_out_q   <= hold_q;
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
            hold_vld_q  <= bus.usr_valid;
            if (bus.usr_valid) hold_q <= bus.usr_cmd;
          end else if (bus.usr_valid) begin
            cmd_out_q   <= bus.usr_cmd;
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end else if (bot_load) begin
            cmd_out_q   <= bus.bot_cmd;
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
          if (bus.usr_valid) begin
            hold_q     <= bus.usr_cmd;
            hold_vld_q <= 1'b1;
            if (hold_vld_q && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cmd_out   = cmd_out_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.demo_mode = demo_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_cmd_sched.sv
// tb_cmd_sched: scenario bench for cmd_sched with a handshake scoreboard
module tb_cmd_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  cmd_sched_if bus();
  cmd_sched #(.BOT_PERIOD(4), .IDLE_TICKS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // inputs change at posedge+1, so values seen here are what the next posedge samples
  always @(negedge clk) begin
    if (rst && bus.cmd_valid && bus.cmd_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: issued %h, required none", bus.cmd_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.cmd_out !== e) begin
          n_fail++;
          $display("FAIL sb_cmd: issued %h, required %h", bus.cmd_out, e);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick_once();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d commands left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
    step();
  endtask
  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: %b, required 0", bus.cmd_valid); end
    if (bus.cmd_out !== 8'h00) begin n_fail++; $display("FAIL rst_out: %h, required 00", bus.cmd_out); end
    if (bus.demo_mode !== 1'b0) begin n_fail++; $display("FAIL rst_demo: %b, required 0", bus.demo_mode); end
    if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop: %h, required 00", bus.drop_cnt); end
    step();
    step();
    rst = 1'b1;
    step();
  endtask
  task automatic test_single();
    bus.cmd_ready = 1'b1;
    bus.usr_cmd = 8'h03;
    bus.usr_valid = 1'b1;
    exp_q.push_back(8'h03);
    step();
    bus.usr_valid = 1'b0;
    n_cmp += 2;
    if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: %b, required 1", bus.cmd_valid); end
    if (bus.cmd_out !== 8'h03) begin n_fail++; $display("FAIL single_out: %h, required 03", bus.cmd_out); end
    step();
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: valid %b, required 0", bus.cmd_valid); end
    drain("single");
  endtask
  task automatic test_hold_drop();
    logic [7:0] cmds[3] = '{8'h01, 8'h02, 8'h04};
    bus.cmd_ready = 1'b0;
    foreach (cmds[i]) begin
      bus.usr_cmd = cmds[i];
      bus.usr_valid = 1'b1;
      step();
    end
    bus.usr_valid = 1'b0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    n_cmp += 3;
    if (bus.cmd_out !== 8'h01) begin n_fail++; $display("FAIL hold_first: %h, required 01", bus.cmd_out); end
    if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: %b, required 1", bus.cmd_valid); end
    if (bus.drop_cnt !== 8'h01) begin n_fail++; $display("FAIL hold_drop: %h, required 01", bus.drop_cnt); end
    step();
    n_cmp++;
    if (bus.cmd_out !== 8'h01) begin n_fail++; $display("FAIL hold_stable: %h, required 01", bus.cmd_out); end
    bus.cmd_ready = 1'b1;
    drain("hold");
  endtask
  task automatic test_demo();
    bus.cmd_ready = 1'b1;
    bus.bot_cmd = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      n_cmp++;
      if (bus.demo_mode !== (i == 8)) begin n_fail++; $display("FAIL demo_enter_t%0d: %b, required %b", i, bus.demo_mode, i == 8); end
      step();
    end
    for (int p = 0; p < 3; p++) begin
      logic [7:0] bc;
      bc = 8'($urandom);
      bus.bot_cmd = bc;
      exp_q.push_back(bc);
      for (int k = 0; k < 4; k++) tick_once();
    end
    drain("demo");
    n_cmp++;
    if (bus.demo_mode !== 1'b1) begin n_fail++; $display("FAIL demo_stay: %b, required 1", bus.demo_mode); end
  endtask
  task automatic test_demo_preempt();
    logic [7:0] bc;
    bc = 8'h3C;
    bus.cmd_ready = 1'b0;
    bus.bot_cmd = bc;
    exp_q.push_back(bc);
    for (int k = 0; k < 4; k++) tick_once();
    n_cmp += 2;
    if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL pre_bot_valid: %b, required 1", bus.cmd_valid); end
    if (bus.cmd_out !== bc) begin n_fail++; $display("FAIL pre_bot_out: %h, required %h", bus.cmd_out, bc); end
    bus.usr_cmd = 8'h5A;
    bus.usr_valid = 1'b1;
    exp_q.push_back(8'h5A);
    step();
    bus.usr_valid = 1'b0;
    n_cmp += 2;
    if (bus.demo_mode !== 1'b0) begin n_fail++; $display("FAIL pre_demo_off: %b, required 0", bus.demo_mode); end
    if (bus.cmd_out !== bc) begin n_fail++; $display("FAIL pre_bot_held: %h, required %h", bus.cmd_out, bc); end
    step();
    step();
    n_cmp++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_out !== bc) begin n_fail++; $display("FAIL pre_bot_wait: %b/%h, required 1/%h", bus.cmd_valid, bus.cmd_out, bc); end
    bus.cmd_ready = 1'b1;
    drain("preempt");
  endtask
  task automatic test_force();
    bus.force_manual = 1'b1;
    bus.cmd_ready = 1'b1;
    bus.bot_cmd = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      tick_once();
      n_cmp++;
      if (bus.demo_mode !== 1'b0 || bus.cmd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL force_t%0d: demo %b valid %b, required 0 0", i, bus.demo_mode, bus.cmd_valid);
      end
    end
    bus.force_manual = 1'b0;
    step();
  endtask
  task automatic test_async_reset();
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick_once();
    bus.cmd_ready = 1'b0;
    bus.bot_cmd = 8'hC3;
    for (int k = 0; k < 4; k++) tick_once();
    n_cmp += 3;
    if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: %b, required 1", bus.cmd_valid); end
    if (bus.demo_mode !== 1'b1) begin n_fail++; $display("FAIL ar_pre_demo: %b, required 1", bus.demo_mode); end
    if (bus.drop_cnt !== 8'h01) begin n_fail++; $display("FAIL ar_pre_drop: %h, required 01", bus.drop_cnt); end
    #2 rst = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: %b, required 0", bus.cmd_valid); end
    if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL ar_drop: %h, required 00", bus.drop_cnt); end
    if (bus.demo_mode !== 1'b0) begin n_fail++; $display("FAIL ar_demo: %b, required 0", bus.demo_mode); end
    if (bus.cmd_out !== 8'h00) begin n_fail++; $display("FAIL ar_out: %h, required 00", bus.cmd_out); end
    step();
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL ar_dropped: valid %b, required 0", bus.cmd_valid); end
    bus.cmd_ready = 1'b1;
    bus.usr_cmd = 8'h11;
    bus.usr_valid = 1'b1;
    exp_q.push_back(8'h11);
    step();
    bus.usr_valid = 1'b0;
    n_cmp++;
    if (bus.cmd_out !== 8'h11) begin n_fail++; $display("FAIL ar_resume: %h, required 11", bus.cmd_out); end
    drain("async");
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.usr_cmd = 8'h00;
    bus.usr_valid = 1'b0;
    bus.bot_cmd = 8'h00;
    bus.force_manual = 1'b0;
    bus.cmd_ready = 1'b0;
    test_reset();
    test_single();
    test_hold_drop();
    test_demo();
    test_demo_preempt();
    test_force();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
